// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx                                                   |
// | Purpose  : Serial receiver, one-entry valid/ready byte output.       |
// |            UART_RX_MAJORITY_EN: 2-of-3 majority sampling per bit.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx #(
    parameter int    DIV      = 16,
    parameter int    BYTESIZE = 8,
    parameter string PARITY   = "NONE",
    parameter int    STOPSIZE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_rxd,
    output logic [BYTESIZE-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_err_frame,
    output logic                rx_err_parity,
    output logic                rx_err_overrun,
    output logic                status_err
);

    localparam int              CW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   c_bit_end   = CW'(DIV - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0]   c_start_pt  = CW'(DIV / 2);
`else
    localparam logic [CW-1:0]   c_start_pt  = CW'(DIV / 2 - 1);
`endif
    localparam bit              c_par_en    = (PARITY != "NONE");
    localparam bit              c_par_odd   = (PARITY == "ODD");
    localparam logic [2:0]      c_data_last = 3'(BYTESIZE - 1);
    localparam logic [2:0]      c_stop_last = 3'(STOPSIZE - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;
    localparam logic [2:0] c_st_wait   = 3'd5;

    logic [1:0]          r_sync;
    logic                r_rxd_prev;
    logic                w_rxd_s;
    logic                w_fall;
    logic                w_bit;
    logic                w_sample;
    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_idx;
    logic [BYTESIZE-1:0] r_shift;
    logic                r_par_err;
    logic                r_frm_err;
    logic                w_par_bad;
    logic                w_frm_final;
    logic                w_shift_en;
    logic                w_par_smp;
    logic                w_stop_smp;
    logic                w_done;

    logic [BYTESIZE-1:0] r_data;
    logic                r_valid;
    logic                r_fe;
    logic                r_pe;
    logic                r_ovr;
    logic                r_serr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= 2'b11;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], uart_rxd};
            r_rxd_prev <= w_rxd_s;
        end
    end

    assign w_rxd_s = r_sync[1];
    assign w_fall  = r_rxd_prev & ~w_rxd_s;

`ifdef UART_RX_MAJORITY_EN
    // Two previous synchronized samples plus the current one form the vote window.
    logic [1:0] r_hist;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rxd_s};
        end
    end
    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxd_s) | (r_hist[0] & w_rxd_s);
`else
    assign w_bit = w_rxd_s;
`endif

    assign w_sample    = (r_state == c_st_start) ? (r_cnt == c_start_pt) : (r_cnt == c_bit_end);
    assign w_par_bad   = c_par_odd ? (w_bit == (^r_shift)) : (w_bit != (^r_shift));
    assign w_frm_final = r_frm_err | ~w_bit;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (w_fall) w_state_nxt = c_st_start;
            c_st_start:  if (w_sample) w_state_nxt = w_bit ? c_st_idle : c_st_data;
            c_st_data:   if (w_sample && (r_idx == c_data_last))
                             w_state_nxt = c_par_en ? c_st_parity : c_st_stop;
            c_st_parity: if (w_sample) w_state_nxt = c_st_stop;
            c_st_stop:   if (w_sample && (r_idx == c_stop_last))
                             w_state_nxt = w_rxd_s ? c_st_idle : c_st_wait;
            c_st_wait:   if (w_rxd_s) w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_shift_en = 1'b0;
        w_par_smp  = 1'b0;
        w_stop_smp = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            c_st_data:   w_shift_en = w_sample;
            c_st_parity: w_par_smp  = w_sample;
            c_st_stop: begin
                w_stop_smp = w_sample;
                w_done     = w_sample && (r_idx == c_stop_last);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            if ((r_state == c_st_idle) || w_sample) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state != w_state_nxt) begin
                r_idx <= '0;
            end else if (w_shift_en || w_stop_smp) begin
                r_idx <= r_idx + 3'd1;
            end
            if (r_state == c_st_idle) begin
                r_par_err <= 1'b0;
                r_frm_err <= 1'b0;
            end
            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            if (w_shift_en) r_shift <= {w_bit, r_shift[BYTESIZE-1:1]};
            if (w_par_smp) r_par_err <= w_par_bad;
            if (w_stop_smp && !w_bit) r_frm_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fe    <= 1'b0;
            r_pe    <= 1'b0;
            r_ovr   <= 1'b0;
            r_serr  <= 1'b0;
        end else begin
            r_ovr  <= 1'b0;
            r_serr <= 1'b0;
            if (r_valid && rx_ready) r_valid <= 1'b0;
            if (w_done) begin
                // A transfer in the completion cycle frees the slot for the new character.
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_fe    <= w_frm_final;
                    r_pe    <= r_par_err;
                    r_valid <= 1'b1;
                    r_serr  <= w_frm_final | r_par_err;
                end else begin
                    r_ovr  <= 1'b1;
                    r_serr <= 1'b1;
                end
            end
        end
    end

    assign rx_data        = r_data;
    assign rx_valid       = r_valid;
    assign rx_err_frame   = r_fe;
    assign rx_err_parity  = r_pe;
    assign rx_err_overrun = r_ovr;
    assign status_err     = r_serr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                |
// | Purpose  : Scoreboard bench for uart_rx, 8N1 and 8E1 instances.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_rx;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       line0, line1, ready0, ready1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, fe0, fe1, pe0, pe1, ovr0, ovr1, se0, se1;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    int         ovr_cnt0 = 0, ovr_cnt1 = 0, se_cnt0 = 0, se_cnt1 = 0;
    int         se_exp0 = 0, se_exp1 = 0, ovr_exp0 = 0;
    bit         rnd_done;

    always #5 clk = ~clk;

    uart_rx #(.DIV(DIV), .BYTESIZE(8), .PARITY("NONE"), .STOPSIZE(1)) dut0 (
        .clk(clk), .rst(rst), .uart_rxd(line0), .rx_data(data0), .rx_valid(valid0),
        .rx_ready(ready0), .rx_err_frame(fe0), .rx_err_parity(pe0),
        .rx_err_overrun(ovr0), .status_err(se0)
    );

    uart_rx #(.DIV(DIV), .BYTESIZE(8), .PARITY("EVEN"), .STOPSIZE(1)) dut1 (
        .clk(clk), .rst(rst), .uart_rxd(line1), .rx_data(data1), .rx_valid(valid1),
        .rx_ready(ready1), .rx_err_frame(fe1), .rx_err_parity(pe1),
        .rx_err_overrun(ovr1), .status_err(se1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input int ch, input logic [9:0] act);
        logic [9:0] e;
        checks++;
        if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL char_ch%0d actual={fe,pe,data}=%03h required=no character", ch, act);
        end else begin
            if (ch == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL char_ch%0d actual={fe,pe,data}=%03h required=%03h", ch, act, e);
            end
        end
    endtask

    // Monitor: every transfer must match the oldest expected character.
    always @(negedge clk) begin
        if (valid0 && ready0) pop_cmp(0, {fe0, pe0, data0});
        if (valid1 && ready1) pop_cmp(1, {fe1, pe1, data1});
        if (ovr0) ovr_cnt0++;
        if (ovr1) ovr_cnt1++;
        if (se0)  se_cnt0++;
        if (se1)  se_cnt1++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int ch, input logic b);
        if (ch == 0) line0 = b;
        else         line1 = b;
        wait_cyc(DIV);
    endtask

    task automatic send(input int ch, input logic [7:0] d, input bit use_par, input bit par,
                        input bit stop);
        drive_bit(ch, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(ch, d[i]);
        if (use_par) drive_bit(ch, par);
        drive_bit(ch, stop);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hello [6];
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C};
        rst = 1'b1; line0 = 1'b1; line1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs0", 32'({data0, valid0, fe0, pe0, ovr0, se0}), 32'h0);
        chk("reset_outputs1", 32'({data1, valid1, fe1, pe1, ovr1, se1}), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cyc(5);

        fork
            begin : chan0
                int n;
                logic [7:0] d;
                // Single "H" with latency measurement
                q0.push_back({2'b00, 8'h48});
                n = 0;
                fork
                    send(0, 8'h48, 0, 0, 1);
                    begin
                        while (!valid0 && n < 300) begin
                            wait_cyc(1);
                            n++;
                        end
                        chk("latency_H", 32'(n >= 153 && n <= 155), 32'h1);
                    end
                join
                // Back-to-back "Hello,"
                for (int i = 0; i < 6; i++) begin
                    q0.push_back({2'b00, hello[i]});
                    send(0, hello[i], 0, 0, 1);
                end
                wait_cyc(20);
                // Short glitch must not produce a character
                line0 = 1'b0;
                wait_cyc(3);
                line0 = 1'b1;
                wait_cyc(40);
                q0.push_back({2'b00, 8'h55});
                send(0, 8'h55, 0, 0, 1);
                wait_cyc(10);
                // Low stop bit, line held low afterwards
                q0.push_back({2'b10, 8'hA5});
                se_exp0++;
                send(0, 8'hA5, 0, 0, 0);
                wait_cyc(40);
                line0 = 1'b1;
                wait_cyc(20);
                q0.push_back({2'b00, 8'h3C});
                send(0, 8'h3C, 0, 0, 1);
                // Overrun, then transfer coinciding with completion
                ready0 = 1'b0;
                q0.push_back({2'b00, 8'h11});
                send(0, 8'h11, 0, 0, 1);
                ovr_exp0++;
                se_exp0++;
                send(0, 8'h22, 0, 0, 1);
                chk("held_data_after_overrun", 32'(data0), 32'h11);
                q0.push_back({2'b00, 8'h33});
                fork
                    send(0, 8'h33, 0, 0, 1);
                    begin
                        wait_cyc(153);
                        ready0 = 1'b1;
                        wait_cyc(1);
                        ready0 = 1'b0;
                    end
                join
                wait_cyc(5);
                ready0 = 1'b1;
                wait_cyc(5);
                // Random characters with random backpressure
                rnd_done = 1'b0;
                fork
                    begin
                        for (int i = 0; i < 20; i++) begin
                            d = 8'($urandom);
                            q0.push_back({2'b00, d});
                            send(0, d, 0, 0, 1);
                            wait_cyc($urandom_range(0, 12));
                        end
                        rnd_done = 1'b1;
                    end
                    begin
                        while (!rnd_done) begin
                            ready0 = 1'($urandom_range(0, 1));
                            wait_cyc(1);
                        end
                    end
                join
                ready0 = 1'b1;
                wait_cyc(20);
            end
            begin : chan1
                logic [7:0] d;
                bit p, perr;
                q1.push_back({2'b01, 8'h07});
                se_exp1++;
                send(1, 8'h07, 1, 0, 1);
                q1.push_back({2'b00, 8'h07});
                send(1, 8'h07, 1, 1, 1);
                for (int i = 0; i < 15; i++) begin
                    d = 8'($urandom);
                    p = 1'($urandom_range(0, 1));
                    perr = (p != (^d));
                    if (perr) se_exp1++;
                    q1.push_back({1'b0, perr, d});
                    send(1, d, 1, p, 1);
                    wait_cyc($urandom_range(0, 12));
                end
                wait_cyc(20);
            end
        join

        // Reset in the middle of a character while an unconsumed byte is held
        ready0 = 1'b0;
        send(0, 8'h5A, 0, 0, 1);
        wait_cyc(5);
        chk("held_before_reset", 32'({valid0, data0}), 32'h15A);
        fork
            send(0, 8'h81, 0, 0, 1);
            begin
                wait_cyc(134);
                rst = 1'b1;
                wait_cyc(1);
                rst = 1'b0;
                @(negedge clk);
                chk("midframe_reset0", 32'({data0, valid0, fe0, pe0, ovr0, se0}), 32'h0);
                chk("midframe_reset1", 32'({data1, valid1, fe1, pe1, ovr1, se1}), 32'h0);
            end
        join
        wait_cyc(20);
        chk("no_char_after_reset", 32'(valid0), 32'h0);
        ready0 = 1'b1;
        q0.push_back({2'b00, 8'h42});
        send(0, 8'h42, 0, 0, 1);
        wait_cyc(30);

        chk("overrun_pulses0", 32'(ovr_cnt0), 32'(ovr_exp0));
        chk("overrun_pulses1", 32'(ovr_cnt1), 32'h0);
        chk("status_pulses0", 32'(se_cnt0), 32'(se_exp0));
        chk("status_pulses1", 32'(se_cnt1), 32'(se_exp1));
        chk("pending_chars0", 32'(q0.size()), 32'h0);
        chk("pending_chars1", 32'(q1.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver stage that consumes the line driven into the uart block's uart_rxd input and produces parallel bytes for the Avalon-side register logic.
- Synchronizes the asynchronous line and detects start bits with glitch rejection.
- Samples each bit mid-period, checks parity and stop bits.
- Holds one received byte in a valid/ready output register, flagging framing, parity and overrun errors.

Parameters:
- DIV, 16, clock cycles per bit (integer, >= 4; bench uses 16, not 1).
- BYTESIZE, 8, data bits per character (5..8).
- PARITY, "NONE", "NONE" / "ODD" / "EVEN".
- STOPSIZE, 1, stop bits checked (1 or 2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- uart_rxd  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  BYTESIZE  received character, LSB first on the line
- rx_valid  output  1  rx_data/flags hold an unconsumed character
- rx_ready  input  1  consumer accepts; transfer = rx_valid & rx_ready
- rx_err_frame  output  1  character had a low stop bit (qualified by rx_valid)
- rx_err_parity  output  1  parity mismatch (qualified by rx_valid; always 0 if PARITY="NONE")
- rx_err_overrun  output  1  one-cycle pulse: completed character dropped, buffer full
- status_err  output  1  OR of the three error conditions, one-cycle pulse at character completion/drop

Interface timing: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst sampled high on a clk edge, may occur mid-character):
  - all outputs 0, rx_data = 0;
  - synchronizer flops = 1;
  - FSM to IDLE, counters 0;
  - any partial character is discarded.
- Synchronizer: 2 flops on uart_rxd give rxd_s (2-cycle latency). All decisions use rxd_s only.
- Bit counter cnt counts 0..DIV-1. Sample point is cnt == DIV/2-1 (integer division) from the start-bit edge, then every DIV cycles.
- FSM states and transitions:
  - IDLE: on rxd_s 1->0, go to START with cnt = 0.
  - START: at the half-bit point:
    - rxd_s == 1 → false start, return to IDLE, nothing reported;
    - else go to DATA with bit index 0 and cnt reloaded for a full DIV period.
  - DATA: sample rxd_s into shift register bit [idx], LSB first. After BYTESIZE samples go to PARITY if enabled, else STOP.
  - PARITY: sample the parity bit.
    - ODD: error if sample != ~^data.
    - EVEN: error if sample != ^data.
  - STOP: sample STOPSIZE stop bits. Any sampled 0 sets the frame error.
    - After the last stop sample, the character completes and goes to the output register.
    - Then go to IDLE if rxd_s == 1, else WAIT_HIGH.
  - WAIT_HIGH (break/framing recovery): stay until rxd_s == 1, then IDLE. No start detection until the line has returned high.
- Output register (1 entry):
  - Loaded on the cycle after the last stop sample: rx_valid = 1, rx_data, rx_err_frame, rx_err_parity.
  - Holds until transfer; rx_valid clears on the cycle after the transfer.
- Overrun: completion while rx_valid = 1 and rx_ready = 0:
  - new character dropped, old data/flags unchanged;
  - rx_err_overrun and status_err pulse one cycle.
- Simultaneous transfer and completion (rx_valid & rx_ready in the completion cycle): new character loaded, rx_valid stays 1, no overrun.
- status_err pulses on load with frame or parity error, and on overrun.
- Latency: rx_valid rises 2 (sync) + start-edge-to-last-stop-sample + 1 cycles after the start edge on uart_rxd.
  - For DIV=16, 8N1: start-edge-to-last-stop-sample = 7 + 9*16 = 151, so latency = 154 cycles (±1 for the asynchronous edge).

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - each sample (start, data, parity, stop) is the 2-of-3 majority of rxd_s at cnt = DIV/2-2, DIV/2-1 and DIV/2;
  - the decision is taken at DIV/2, so rx_valid timing shifts +1 cycle;
  - a single-cycle glitch at any sample point is rejected.
- Undefined: single sample at DIV/2-1 exactly as above.

Test Plan:
- DIV=16, 8N1. Drive "H" (0x48) serially, rx_ready=1 → rx_valid for 1 cycle, rx_data = 0x48, all errors 0. Repeat for back-to-back "Hello," with no idle gap → 6 correct bytes in order.
- 3-cycle low glitch on idle line → no rx_valid, FSM back in IDLE, a following 0x55 received correctly.
- Stop bit driven 0 on 0xA5, line held low 40 cycles → rx_data = 0xA5, rx_err_frame = 1, status_err pulse. No new character until the line goes high; the next 0x3C is received cleanly.
- PARITY="EVEN": 0x07 sent with parity 0 → rx_err_parity = 1. Same byte with parity 1 → rx_err_parity = 0.
- rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11, rx_err_overrun one-cycle pulse at 0x22 completion. Then assert rx_ready exactly in the completion cycle of 0x33 → 0x33 loaded, no overrun.
- Assert rst for 1 cycle in mid-DATA of 0x81 → outputs 0, no rx_valid for that character, the next 0x42 received correctly.
